// File: rtl/input_stream_loader.sv
// AXI Stream slave that parses a 4-word load header, validates it and scatters the
// payload BRAM-major into a contiguous BRAM range through an external write port.
module input_stream_loader #(
  parameter int              DW         = 16,
  parameter int              NUM_BRAMS  = 16,
  parameter int              ADDR_WIDTH = 10,
  parameter int              BRAM_DEPTH = 512,
  parameter logic [DW-1:0]   LOAD_MAGIC = 16'h10AD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_enable,
  input  logic [DW-1:0]         s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [NUM_BRAMS-1:0]  ext_write_en,
  output logic [ADDR_WIDTH-1:0] ext_write_addr,
  output logic [DW-1:0]         ext_write_data,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code,
  output logic [15:0]           words_written,
  output logic [2:0]            state_debug,
  output logic                  busy
);

  localparam int BW = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_RECV_HDR     = 3'd1;
  localparam logic [2:0] S_RECV_PAYLOAD = 3'd2;
  localparam logic [2:0] S_DRAIN        = 3'd3;
  localparam logic [2:0] S_FINISH       = 3'd4;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MAGIC    = 2'd1;
  localparam logic [1:0] ERR_GEOMETRY = 2'd2;
  localparam logic [1:0] ERR_TLAST    = 2'd3;

  // Limits widened by one bit so the start+num sum cannot wrap
  localparam logic [DW:0] BANK_LIM  = (DW+1)'(NUM_BRAMS);
  localparam logic [DW:0] DEPTH_LIM = (DW+1)'(BRAM_DEPTH);

  logic [2:0]            r_state;
  logic [1:0]            r_hdrCnt;
  logic [DW-1:0]         r_hdrMagic;
  logic [DW-1:0]         r_hdrStart;
  logic [DW-1:0]         r_hdrNum;
  logic [BW-1:0]         r_bramIdx;
  logic [BW-1:0]         r_lastBram;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addrLast;
  logic [NUM_BRAMS-1:0]  r_writeEn;
  logic [ADDR_WIDTH-1:0] r_writeAddr;
  logic [DW-1:0]         r_writeData;
  logic [1:0]            r_errCode;
  logic [15:0]           r_wordsWritten;

  logic                  w_accept;
  logic                  w_magicBad;
  logic                  w_geomBad;
  logic                  w_finalWord;
  logic [DW:0]           w_bankEnd;
  logic [NUM_BRAMS-1:0]  w_bramOneHot;

  assign s_axis_tready = (r_state == S_RECV_HDR) || (r_state == S_RECV_PAYLOAD) ||
                         (r_state == S_DRAIN);
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // Header checks use word 3 straight off the bus, so validation costs no extra cycle
  assign w_bankEnd   = {1'b0, r_hdrStart} + {1'b0, r_hdrNum};
  assign w_magicBad  = (r_hdrMagic != LOAD_MAGIC);
  assign w_geomBad   = (r_hdrNum == '0) || (w_bankEnd > BANK_LIM) ||
                       (s_axis_tdata == '0) || ({1'b0, s_axis_tdata} > DEPTH_LIM);
  assign w_finalWord = (r_bramIdx == r_lastBram) && (r_addr == r_addrLast);
  assign w_bramOneHot = {{(NUM_BRAMS-1){1'b0}}, 1'b1} << r_bramIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_hdrCnt       <= '0;
      r_hdrMagic     <= '0;
      r_hdrStart     <= '0;
      r_hdrNum       <= '0;
      r_bramIdx      <= '0;
      r_lastBram     <= '0;
      r_addr         <= '0;
      r_addrLast     <= '0;
      r_writeEn      <= '0;
      r_writeAddr    <= '0;
      r_writeData    <= '0;
      r_errCode      <= ERR_OK;
      r_wordsWritten <= '0;
    end else begin
      r_writeEn <= '0;
      case (r_state)
        S_IDLE: begin
          if (load_enable) begin
            r_state        <= S_RECV_HDR;
            r_hdrCnt       <= '0;
            r_errCode      <= ERR_OK;
            r_wordsWritten <= '0;
          end
        end

        S_RECV_HDR: begin
          if (w_accept) begin
            r_hdrCnt <= r_hdrCnt + 2'd1;
            case (r_hdrCnt)
              2'd0:    r_hdrMagic <= s_axis_tdata;
              2'd1:    r_hdrStart <= s_axis_tdata;
              2'd2:    r_hdrNum   <= s_axis_tdata;
              default: ;
            endcase
            if (s_axis_tlast) begin
              r_errCode <= ERR_TLAST;
              r_state   <= S_FINISH;
            end else if (r_hdrCnt == 2'd3) begin
              if (w_magicBad) begin
                r_errCode <= ERR_MAGIC;
                r_state   <= S_DRAIN;
              end else if (w_geomBad) begin
                r_errCode <= ERR_GEOMETRY;
                r_state   <= S_DRAIN;
              end else begin
                r_state    <= S_RECV_PAYLOAD;
                r_bramIdx  <= BW'(r_hdrStart);
                r_lastBram <= BW'(r_hdrStart + r_hdrNum - {{(DW-1){1'b0}}, 1'b1});
                r_addr     <= '0;
                r_addrLast <= ADDR_WIDTH'(s_axis_tdata - {{(DW-1){1'b0}}, 1'b1});
              end
            end
          end
        end

        S_RECV_PAYLOAD: begin
          if (w_accept) begin
            r_writeEn   <= w_bramOneHot;
            r_writeAddr <= r_addr;
            r_writeData <= s_axis_tdata;
            if (r_wordsWritten != 16'hFFFF)
              r_wordsWritten <= r_wordsWritten + 16'd1;
            // The final word is written even when its tlast is missing
            if (w_finalWord) begin
              if (s_axis_tlast) begin
                r_state <= S_FINISH;
              end else begin
                r_errCode <= ERR_TLAST;
                r_state   <= S_DRAIN;
              end
            end else if (s_axis_tlast) begin
              r_errCode <= ERR_TLAST;
              r_state   <= S_FINISH;
            end else if (r_addr == r_addrLast) begin
              r_addr    <= '0;
              r_bramIdx <= r_bramIdx + {{(BW-1){1'b0}}, 1'b1};
            end else begin
              r_addr <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
          end
        end

        S_DRAIN: begin
          if (w_accept && s_axis_tlast)
            r_state <= S_FINISH;
        end

        S_FINISH: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ext_write_en   = r_writeEn;
  assign ext_write_addr = r_writeAddr;
  assign ext_write_data = r_writeData;
  assign load_done      = (r_state == S_FINISH);
  assign load_error     = (r_state == S_FINISH) && (r_errCode != ERR_OK);
  assign err_code       = r_errCode;
  assign words_written  = r_wordsWritten;
  assign state_debug    = r_state;
  assign busy           = (r_state != S_IDLE);

endmodule
